// File: rtl/ball_multi_motion.sv
// ----------------------------------------------------------------------------
// ball_multi_motion
//   Motion and graphics engine for NUM_BALLS independent square balls on a
//   640x480 raster. Once per frame (rising edge of the registered vsync) a
//   sequencer walks the balls, one per clock, and moves each one by SPEED on
//   both axes. A ball bounces off both edges of each axis. The pixel path
//   draws the balls over a dotted background grid. RGB and the syncs leave
//   through one register stage, so they stay aligned.
//
// Ports
//   clk         in   pixel clock (clk25)
//   reset       in   synchronous, active-high
//   stop        in   1 = freeze positions (directions kept)
//   hpos/vpos   in   beam position from hvsync_generator
//   display_on  in   active-video flag
//   hsync_in    in   raw hsync
//   vsync_in    in   raw vsync
//   hsync/vsync out  syncs delayed by 1 clk
//   rgb         out  {b,g,r}, registered
//   ledh/ledv   out  some ball hit an X / Y edge in the last completed frame
//   busy        out  update sequencer active
// ----------------------------------------------------------------------------
module ball_multi_motion #(
   parameter int NUM_BALLS   = 4,
   parameter int BALL_SIZE   = 4,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SPEED       = 2,
   parameter int INIT_H_STEP = 64,
   parameter int INIT_V_STEP = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stop,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       display_on,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb,
   output logic       ledh,
   output logic       ledv,
   output logic       busy
);

   localparam logic [10:0] LIM_X  = 11'(H_ACTIVE - BALL_SIZE);
   localparam logic [10:0] LIM_Y  = 11'(V_ACTIVE - BALL_SIZE);
   localparam logic [10:0] STEP   = 11'(SPEED);
   localparam logic [2:0]  LAST_K = 3'(NUM_BALLS - 1);
   localparam logic [9:0]  SIZE   = 10'(BALL_SIZE);

   typedef enum logic {S_IDLE, S_UPDATE} state_t;

   state_t      r_state, w_state_next;
   logic [2:0]  r_k, w_k_next;
   logic        w_last;

   logic        r_vsync, r_vs_prev, r_hsync;
   logic [2:0]  r_rgb;
   logic        r_ledh, r_ledv, r_hith, r_hitv;
   logic        w_tick;

   logic [9:0]  r_x [NUM_BALLS];
   logic [9:0]  r_y [NUM_BALLS];
   logic        r_dx [NUM_BALLS];   // 1 = moving +
   logic        r_dy [NUM_BALLS];

   // Ball currently addressed by the sequencer and its next state
   logic [9:0]  w_cur_x, w_cur_y, w_nx, w_ny;
   logic        w_cur_dx, w_cur_dy, w_ndx, w_ndy, w_hx, w_hy;
   logic [10:0] w_xp, w_yp;

   logic [NUM_BALLS-1:0] w_in;
   logic [2:0]  w_rgb;

   // The registered vsync doubles as the delayed sync output; one more stage
   // gives the previous value for the rising-edge tick.
   assign w_tick = r_vsync & ~r_vs_prev;

   // ---------------- sequencer FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_k     <= w_k_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_k_next     = r_k;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_state_next = S_UPDATE;
               w_k_next     = 3'd0;
            end
         end
         S_UPDATE: begin
            if (r_k == LAST_K) begin
               w_state_next = S_IDLE;
               w_k_next     = 3'd0;
               w_last       = 1'b1;
            end else begin
               w_k_next = r_k + 3'd1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- per-ball motion ----------------
   // Select the addressed ball with a compare loop rather than an index so the
   // 3-bit counter never reaches past the array.
   always_comb begin
      w_cur_x  = 10'd0;
      w_cur_y  = 10'd0;
      w_cur_dx = 1'b0;
      w_cur_dy = 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
         if (r_k == 3'(i)) begin
            w_cur_x  = r_x[i];
            w_cur_y  = r_y[i];
            w_cur_dx = r_dx[i];
            w_cur_dy = r_dy[i];
         end
      end
   end

   // 11-bit sums so pos+SPEED cannot wrap before the limit compare.
   assign w_xp = {1'b0, w_cur_x} + STEP;
   assign w_yp = {1'b0, w_cur_y} + STEP;

   always_comb begin
      w_nx  = w_cur_x;
      w_ndx = w_cur_dx;
      w_hx  = 1'b0;
      w_ny  = w_cur_y;
      w_ndy = w_cur_dy;
      w_hy  = 1'b0;
      if (!stop) begin
         if (w_cur_dx) begin
            if (w_xp >= LIM_X) begin
               w_nx = LIM_X[9:0]; w_ndx = 1'b0; w_hx = 1'b1;
            end else begin
               w_nx = w_xp[9:0];
            end
         end else begin
            if ({1'b0, w_cur_x} <= STEP) begin
               w_nx = 10'd0; w_ndx = 1'b1; w_hx = 1'b1;
            end else begin
               w_nx = w_cur_x - STEP[9:0];
            end
         end
         if (w_cur_dy) begin
            if (w_yp >= LIM_Y) begin
               w_ny = LIM_Y[9:0]; w_ndy = 1'b0; w_hy = 1'b1;
            end else begin
               w_ny = w_yp[9:0];
            end
         end else begin
            if ({1'b0, w_cur_y} <= STEP) begin
               w_ny = 10'd0; w_ndy = 1'b1; w_hy = 1'b1;
            end else begin
               w_ny = w_cur_y - STEP[9:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_BALLS; i++) begin
            r_x[i]  <= 10'(INIT_H_STEP * i);
            r_y[i]  <= 10'(INIT_V_STEP * i);
            r_dx[i] <= ((i % 2) == 0);
            r_dy[i] <= 1'b1;
         end
         r_hith <= 1'b0;
         r_hitv <= 1'b0;
         r_ledh <= 1'b0;
         r_ledv <= 1'b0;
      end else if (r_state == S_UPDATE) begin
         for (int i = 0; i < NUM_BALLS; i++) begin
            if (r_k == 3'(i)) begin
               r_x[i]  <= w_nx;
               r_y[i]  <= w_ny;
               r_dx[i] <= w_ndx;
               r_dy[i] <= w_ndy;
            end
         end
         // The last ball's own hit is folded in directly, since its flag
         // would otherwise land in the accumulator one clock too late.
         if (w_last) begin
            r_ledh <= r_hith | w_hx;
            r_ledv <= r_hitv | w_hy;
            r_hith <= 1'b0;
            r_hitv <= 1'b0;
         end else begin
            r_hith <= r_hith | w_hx;
            r_hitv <= r_hitv | w_hy;
         end
      end
   end

   // ---------------- pixel path ----------------
   // Unsigned 10-bit differences: a beam left of / above the ball wraps to a
   // large value and falls outside the box without a second compare.
   generate
      for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_ball_hit
         logic [9:0] w_dh, w_dv;
         assign w_dh      = hpos - r_x[gi];
         assign w_dv      = vpos - r_y[gi];
         assign w_in[gi]  = (w_dh < SIZE) && (w_dv < SIZE);
      end
   endgenerate

   always_comb begin
      w_rgb = 3'b000;
      if (display_on) begin
         if (hpos[2:0] == 3'd0 && vpos[2:0] == 3'd0) begin
            w_rgb = 3'b010;
         end
         // Walk downward so the lowest covering index is the one left standing.
         for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (w_in[i]) begin
               w_rgb = 3'((i % 7) + 1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rgb     <= 3'b000;
         r_hsync   <= 1'b0;
         r_vsync   <= 1'b0;
         r_vs_prev <= 1'b0;
      end else begin
         r_rgb     <= w_rgb;
         r_hsync   <= hsync_in;
         r_vsync   <= vsync_in;
         r_vs_prev <= r_vsync;
      end
   end

   assign rgb   = r_rgb;
   assign hsync = r_hsync;
   assign vsync = r_vsync;
   assign ledh  = r_ledh;
   assign ledv  = r_ledv;
   assign busy  = (r_state == S_UPDATE);

endmodule

// File: tb/tb_ball_multi_motion.sv
// Bench for ball_multi_motion: frame-by-frame reference model of ball motion
// and bounce, pixel probes at model-predicted ball/background locations.
module tb_ball_multi_motion;

   localparam int NB = 4;
   localparam int BS = 4;
   localparam int HA = 640;
   localparam int VA = 480;
   localparam int SP = 2;

   logic       clk = 1'b0;
   logic       reset, stop, display_on, hsync_in, vsync_in;
   logic [9:0] hpos, vpos;
   logic       hsync, vsync, ledh, ledv, busy;
   logic [2:0] rgb;

   ball_multi_motion dut (
      .clk(clk), .reset(reset), .stop(stop), .hpos(hpos), .vpos(vpos),
      .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hsync(hsync), .vsync(vsync), .rgb(rgb), .ledh(ledh), .ledv(ledv),
      .busy(busy)
   );

   always #20 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int mx [NB];
   int my [NB];
   bit mdx [NB];
   bit mdy [NB];
   bit exp_lh, exp_lv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         mx[i]  = 64 * i;
         my[i]  = 32 * i;
         mdx[i] = (i % 2 == 0);
         mdy[i] = 1'b1;
      end
      exp_lh = 0;
      exp_lv = 0;
   endtask

   task automatic step_axis(inout int p, inout bit d, input int lim, output bit hit);
      hit = 0;
      if (d) begin
         if (p + SP >= lim) begin p = lim; d = 0; hit = 1; end
         else p = p + SP;
      end else begin
         if (p <= SP) begin p = 0; d = 1; hit = 1; end
         else p = p - SP;
      end
   endtask

   task automatic model_frame(input bit st);
      bit h, v;
      exp_lh = 0;
      exp_lv = 0;
      if (!st) begin
         for (int i = 0; i < NB; i++) begin
            step_axis(mx[i], mdx[i], HA - BS, h);
            step_axis(my[i], mdy[i], VA - BS, v);
            exp_lh |= h;
            exp_lv |= v;
         end
      end
   endtask

   function automatic int model_pix(input int h, input int v, input bit disp);
      if (!disp) return 0;
      for (int i = 0; i < NB; i++)
         if (h >= mx[i] && h < mx[i] + BS && v >= my[i] && v < my[i] + BS)
            return (i % 7) + 1;
      if (h % 8 == 0 && v % 8 == 0) return 2;
      return 0;
   endfunction

   task automatic probe(input int h, input int v, input bit disp, input bit hs);
      @(negedge clk);
      hpos = 10'(h); vpos = 10'(v); display_on = disp; hsync_in = hs;
      @(negedge clk);
      $display("probe h=%0d v=%0d disp=%0d rgb=%0d", h, v, disp, rgb);
      check("rgb", 32'(rgb), 32'(model_pix(h, v, disp)));
      check("hsync", 32'(hsync), 32'(hs));
   endtask

   task automatic frame(input bit st);
      int nbusy;
      @(negedge clk);
      stop = st; vsync_in = 1'b1; nbusy = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) nbusy++;
      end
      check("vsync", 32'(vsync), 32'd1);
      vsync_in = 1'b0;
      model_frame(st);
      $display("frame stop=%0d busy=%0d ledh=%0d ledv=%0d b0=(%0d,%0d)",
               st, nbusy, ledh, ledv, mx[0], my[0]);
      check("busy_len", 32'(nbusy), 32'(NB));
      check("ledh", 32'(ledh), 32'(exp_lh));
      check("ledv", 32'(ledv), 32'(exp_lv));
   endtask

   task automatic probe_balls();
      int b, h, v;
      b = $urandom_range(0, NB - 1);
      h = mx[b] + $urandom_range(0, BS - 1);
      v = my[b] + $urandom_range(0, BS - 1);
      probe(h, v, 1'b1, 1'($urandom));
      h = (mx[b] + BS) % HA;   // just right of the ball
      probe(h, v, 1'b1, 1'($urandom));
      v = (my[b] == 0) ? 0 : my[b] - 1;   // just above (or on) the ball
      probe(mx[b], v, 1'b1, 1'($urandom));
      probe(8 * $urandom_range(0, 79), 8 * $urandom_range(0, 59), 1'b1, 1'($urandom));
      if ($urandom_range(0, 7) == 0) probe(mx[b], my[b], 1'b0, 1'b0);
   endtask

   initial begin
      int n;
      bit st;
      reset = 1'b1; stop = 1'b0; display_on = 1'b1; hsync_in = 1'b1;
      vsync_in = 1'b0; hpos = 10'd0; vpos = 10'd0;
      model_reset();
      repeat (3) @(negedge clk);
      $display("reset rgb=%0d hsync=%0d vsync=%0d busy=%0d", rgb, hsync, vsync, busy);
      check("rst_rgb", 32'(rgb), 32'd0);
      check("rst_hsync", 32'(hsync), 32'd0);
      check("rst_vsync", 32'(vsync), 32'd0);
      check("rst_ledh", 32'(ledh), 32'd0);
      check("rst_ledv", 32'(ledv), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      hsync_in = 1'b0;
      reset = 1'b0;

      // Initial placement, then first frame: ball0 -> (2,2), ball1 -> (62,34)
      probe(64, 32, 1'b1, 1'b1);
      probe(0, 0, 1'b1, 1'b0);
      frame(1'b0);
      probe(2, 2, 1'b1, 1'b0);
      probe(62, 34, 1'b1, 1'b1);
      probe(64, 32, 1'b1, 1'b0);

      // Stop for three frames, then resume
      repeat (3) begin frame(1'b1); probe_balls(); end
      frame(1'b0);
      probe_balls();

      // Long random run: reaches both edges on both axes for several balls
      for (int f = 0; f < 750; f++) begin
         st = ($urandom_range(0, 7) == 0);
         frame(st);
         probe_balls();
      end

      // Reset two clocks into the update sequence
      @(negedge clk);
      stop = 1'b0; vsync_in = 1'b1; n = 0;
      while (!busy && n < 10) begin @(negedge clk); n++; end
      check("busy_seen", 32'(busy), 32'd1);
      @(negedge clk);
      reset = 1'b1; vsync_in = 1'b0;
      @(negedge clk);
      $display("mid-update reset busy=%0d", busy);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ledh", 32'(ledh), 32'd0);
      reset = 1'b0;
      model_reset();
      probe(64, 32, 1'b1, 1'b0);
      probe(0, 0, 1'b1, 1'b1);
      probe(192, 96, 1'b1, 1'b0);
      repeat (3) begin frame(1'b0); probe_balls(); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
